dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Sequences and shares the single-port data memory between two requesters: port A (CPU load/store)
//  and port B (program loader / debug). Clears memory after reset, then round-robin arbitrates
//  req/ack transactions onto the memory command bus (mem_en / mem_rw / mem_addr / mem_wdata).
//  Sits between the CPU datapath and data memory; replaces ad-hoc file loads with port-B writes.
// PARAMETERS
//  ADDR_W          16  implemented address bits; addr[31:ADDR_W] must be zero
//  CLEAR_DEPTH  65536  words zeroed after reset (addresses 0..CLEAR_DEPTH-1)
//  CLEAR_ON_RESET   1  1: run CLEAR after reset; 0: go straight to IDLE
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   synchronous reset, active-high
//  a_req       in   1   A request; held with a_we/a_addr/a_wdata stable until a_ack
//  a_we        in   1   A 1=write, 0=read
//  a_addr      in   32  A word address
//  a_wdata     in   32  A write data
//  a_ack       out  1   A one-cycle completion pulse
//  a_rdata     out  32  A read data, valid while a_ack=1 (read, no error)
//  a_err       out  1   A out-of-range address, pulses with a_ack
//  b_req/b_we/b_addr/b_wdata/b_ack/b_rdata/b_err   same as A, for port B
//  busy        out  1   1 in any state except IDLE
//  clear_done  out  1   1 once CLEAR has finished; stays 1 until next rst
//  mem_en      out  1   memory enable (one cycle per access)
//  mem_rw      out  1   memory 1=write, 0=read
//  mem_addr    out  32  memory address
//  mem_wdata   out  32  memory write data
//  mem_rdata   in   32  memory read data, valid the cycle after mem_en=1,mem_rw=0
// BEHAVIOUR
//  - All outputs registered. While rst=1 (sampled at posedge): all outputs 0, clr_cnt=0,
//    last_grant=B, state=CLEAR (CLEAR_ON_RESET=1) or IDLE (=0). clear_done=1 cycle after rst
//    deasserts when CLEAR_ON_RESET=0.
//  - CLEAR: each cycle mem_en=1, mem_rw=1, mem_addr=clr_cnt, mem_wdata=0; clr_cnt++.
//    Address CLEAR_DEPTH-1 issued -> next cycle IDLE, clear_done=1. Requests ignored (held, not acked).
//  - IDLE: if neither req -> stay. If one req -> grant it. If both -> grant port != last_grant
//    (A wins first after reset). Latch we/addr/wdata of the winner; update last_grant.
//    If latched addr[31:ADDR_W]!=0 -> RESP with err, no memory access; else -> ISSUE.
//  - ISSUE (1 cycle): mem_en=1, mem_rw=we, mem_addr/mem_wdata = latched values -> RESP.
//  - RESP (1 cycle): mem_en=0; winner ack=1; rdata=mem_rdata for reads, 0 for writes/err;
//    err as latched -> IDLE. Loser ack/err stay 0.
//  - Timing: req sampled in cycle T (IDLE), mem_en in T+1, ack in T+2; next grant in T+3.
//    Sustained contention alternates A,B,A,B; neither port starves (max wait 1 transaction).
//  - Requester must drop req the cycle after ack or it is re-granted as a new transaction.
//    Dropping req before ack is illegal; the latched command still completes and acks.
//  - mem_en is never asserted for two consecutive cycles outside CLEAR; never with err.
//  - rst mid-transaction (any state): transaction abandoned, no ack, outputs 0 next cycle,
//    CLEAR restarts at address 0; a still-held req is serviced after clear_done.
// TESTING
//  1 CLEAR_DEPTH=8, rst 2 cycles -> mem_en=1,rw=1,wdata=0 with addr 0..7 on 8 consecutive
//    cycles, then clear_done=1; a_req held throughout gets no ack until after clear_done.
//  2 A write addr 0x10 data 0xDEADBEEF, then A read 0x10 -> a_ack 2 cycles after each req
//    sample, mem_en one cycle each, a_rdata=0xDEADBEEF, a_err=0.
//  3 a_req and b_req (reads, 0x1 / 0x2) both held high for 4 transactions -> grants A,B,A,B;
//    mem_addr sequence 1,2,1,2; acks 3 cycles apart.
//  4 b_req read addr 0x0001_0000 (ADDR_W=16) -> b_ack=1, b_err=1, b_rdata=0, mem_en stays 0.
//  5 rst asserted during ISSUE of A write -> a_ack never pulses, all outputs 0 next cycle,
//    CLEAR restarts at mem_addr=0, clear_done=0.
//  6 CLEAR_ON_RESET=0 -> clear_done=1 and state IDLE the cycle after rst drops; a_req
//    read of 0x3 acks 2 cycles later with a_rdata = memory contents.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between requester A (CPU) and requester B (loader/debug).
// After reset it zeroes the memory, then it grants req/ack transactions round-robin.
module dmem_arbiter #(
   parameter int ADDR_W         = 16,
   parameter int CLEAR_DEPTH    = 65536,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [31:0] a_addr,
   input  logic [31:0] a_wdata,
   output logic        a_ack,
   output logic [31:0] a_rdata,
   output logic        a_err,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [31:0] b_addr,
   input  logic [31:0] b_wdata,
   output logic        b_ack,
   output logic [31:0] b_rdata,
   output logic        b_err,
   output logic        busy,
   output logic        clear_done,
   output logic        mem_en,
   output logic        mem_rw,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_ISSUE, S_RESP} state_t;

   localparam logic [31:0] CLR_LAST = 32'(CLEAR_DEPTH - 1);

   state_t      state;
   logic [31:0] clr_cnt;
   logic        last_b;
   logic        owner_b;
   logic        rd_pend;

   logic        grant_a;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_bad;

   // A wins on contention unless it was the previous winner.
   always_comb begin
      grant_a   = a_req && (!b_req || last_b);
      req_we    = grant_a ? a_we    : b_we;
      req_addr  = grant_a ? a_addr  : b_addr;
      req_wdata = grant_a ? a_wdata : b_wdata;
      req_bad   = (req_addr >> ADDR_W) != 32'd0;
   end

   // Outputs are registered on entry to a state, so they line up with the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
         clr_cnt    <= '0;
         last_b     <= 1'b1;
         owner_b    <= 1'b0;
         rd_pend    <= 1'b0;
         a_ack      <= 1'b0;
         a_err      <= 1'b0;
         b_ack      <= 1'b0;
         b_err      <= 1'b0;
         busy       <= 1'b0;
         clear_done <= 1'b0;
         mem_en     <= 1'b0;
         mem_rw     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         mem_en    <= 1'b0;
         mem_rw    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         a_ack     <= 1'b0;
         a_err     <= 1'b0;
         b_ack     <= 1'b0;
         b_err     <= 1'b0;
         case (state)
            S_CLEAR: begin
               mem_en   <= 1'b1;
               mem_rw   <= 1'b1;
               mem_addr <= clr_cnt;
               clr_cnt  <= clr_cnt + 32'd1;
               busy     <= 1'b1;
               if (clr_cnt == CLR_LAST) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            S_IDLE: begin
               clear_done <= 1'b1;
               busy       <= 1'b0;
               if (a_req || b_req) begin
                  last_b  <= !grant_a;
                  owner_b <= !grant_a;
                  rd_pend <= !req_we && !req_bad;
                  busy    <= 1'b1;
                  if (req_bad) begin
                     state <= S_RESP;
                     a_ack <= grant_a;
                     a_err <= grant_a;
                     b_ack <= !grant_a;
                     b_err <= !grant_a;
                  end else begin
                     state     <= S_ISSUE;
                     mem_en    <= 1'b1;
                     mem_rw    <= req_we;
                     mem_addr  <= req_addr;
                     mem_wdata <= req_wdata;
                  end
               end
            end
            S_ISSUE: begin
               state <= S_RESP;
               busy  <= 1'b1;
               a_ack <= !owner_b;
               b_ack <= owner_b;
            end
            S_RESP: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Read data arrives from the memory's own output register during the ack cycle.
   assign a_rdata = (a_ack && rd_pend) ? mem_rdata : 32'd0;
   assign b_rdata = (b_ack && rd_pend) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance with a short clear, one without clear,
// each attached to a small registered-read memory model.
module tb_dmem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // instance with CLEAR after reset
   logic        rst, a_req, a_we, b_req, b_we;
   logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
   logic        a_ack, a_err, b_ack, b_err, busy, clear_done, mem_en, mem_rw;
   logic [31:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [31:0] mem1 [0:255];

   // instance without CLEAR
   logic        n_rst, n_a_req, n_a_we, n_b_req, n_b_we;
   logic [31:0] n_a_addr, n_a_wdata, n_b_addr, n_b_wdata;
   logic        n_a_ack, n_a_err, n_b_ack, n_b_err, n_busy, n_clear_done, n_mem_en, n_mem_rw;
   logic [31:0] n_a_rdata, n_b_rdata, n_mem_addr, n_mem_wdata, n_mem_rdata;
   logic [31:0] mem2 [0:255];

   dmem_arbiter #(.ADDR_W(16), .CLEAR_DEPTH(8), .CLEAR_ON_RESET(1'b1)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
      .busy(busy), .clear_done(clear_done),
      .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   dmem_arbiter #(.ADDR_W(16), .CLEAR_DEPTH(8), .CLEAR_ON_RESET(1'b0)) dut_nc (
      .clk(clk), .rst(n_rst),
      .a_req(n_a_req), .a_we(n_a_we), .a_addr(n_a_addr), .a_wdata(n_a_wdata),
      .a_ack(n_a_ack), .a_rdata(n_a_rdata), .a_err(n_a_err),
      .b_req(n_b_req), .b_we(n_b_we), .b_addr(n_b_addr), .b_wdata(n_b_wdata),
      .b_ack(n_b_ack), .b_rdata(n_b_rdata), .b_err(n_b_err),
      .busy(n_busy), .clear_done(n_clear_done),
      .mem_en(n_mem_en), .mem_rw(n_mem_rw), .mem_addr(n_mem_addr), .mem_wdata(n_mem_wdata),
      .mem_rdata(n_mem_rdata)
   );

   always @(posedge clk) begin
      if (mem_en && mem_rw)  mem1[mem_addr[7:0]] <= mem_wdata;
      if (mem_en && !mem_rw) mem_rdata <= mem1[mem_addr[7:0]];
      if (n_mem_en && n_mem_rw)  mem2[n_mem_addr[7:0]] <= n_mem_wdata;
      if (n_mem_en && !n_mem_rw) n_mem_rdata <= mem2[n_mem_addr[7:0]];
   end

   // one line per completed transaction
   always @(negedge clk) begin
      if (a_ack)   $display("txn A   ack err=%0d rdata=%h", a_err, a_rdata);
      if (b_ack)   $display("txn B   ack err=%0d rdata=%h", b_err, b_rdata);
      if (n_a_ack) $display("txn nc-A ack err=%0d rdata=%h", n_a_err, n_a_rdata);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_req = 1'b1; a_we = 1'b0; a_addr = 32'h5; a_wdata = 32'h0;
      tick();
      tick();
      checks++;
      if ({a_ack, a_err, b_ack, b_err, busy, clear_done, mem_en, mem_rw, mem_addr, mem_wdata} !== 72'd0) begin
         failures++;
         $display("FAIL reset_outputs: got ack/err=%b%b%b%b busy=%b cd=%b en=%b rw=%b addr=%h wd=%h, required all 0",
                  a_ack, a_err, b_ack, b_err, busy, clear_done, mem_en, mem_rw, mem_addr, mem_wdata);
      end
   endtask

   task automatic test_clear();
      logic [31:0] exp_addr;
      logic        exp_busy;
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         exp_addr = k;
         exp_busy = (k < 7);
         checks++;
         if ({mem_en, mem_rw, mem_addr, mem_wdata, a_ack, clear_done, busy} !== {1'b1, 1'b1, exp_addr, 32'd0, 1'b0, 1'b0, exp_busy}) begin
            failures++;
            $display("FAIL clear_word%0d: got en=%b rw=%b addr=%h wd=%h ack=%b cd=%b busy=%b, required en=1 rw=1 addr=%h wd=0 ack=0 cd=0 busy=%b",
                     k, mem_en, mem_rw, mem_addr, mem_wdata, a_ack, clear_done, busy, exp_addr, exp_busy);
         end
      end
      tick();
      checks++;
      if ({clear_done, busy, mem_en, mem_rw, mem_addr, a_ack} !== {1'b1, 1'b1, 1'b1, 1'b0, 32'h5, 1'b0}) begin
         failures++;
         $display("FAIL clear_done_then_grant: got cd=%b busy=%b en=%b rw=%b addr=%h ack=%b, required cd=1 busy=1 en=1 rw=0 addr=5 ack=0",
                  clear_done, busy, mem_en, mem_rw, mem_addr, a_ack);
      end
      tick();
      checks++;
      if ({a_ack, a_err, a_rdata, mem_en} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
         failures++;
         $display("FAIL held_req_ack: got ack=%b err=%b rdata=%h en=%b, required ack=1 err=0 rdata=0 en=0",
                  a_ack, a_err, a_rdata, mem_en);
      end
      a_req = 1'b0;
      tick();
      checks++;
      if ({a_ack, busy, mem_en} !== 3'b000) begin
         failures++;
         $display("FAIL back_to_idle: got ack=%b busy=%b en=%b, required 0 0 0", a_ack, busy, mem_en);
      end
   endtask

   task automatic test_write_read();
      a_req = 1'b1; a_we = 1'b1; a_addr = 32'h10; a_wdata = 32'hDEADBEEF;
      tick();
      checks++;
      if ({mem_en, mem_rw, mem_addr, mem_wdata, a_ack} !== {1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0}) begin
         failures++;
         $display("FAIL write_issue: got en=%b rw=%b addr=%h wd=%h ack=%b, required en=1 rw=1 addr=10 wd=deadbeef ack=0",
                  mem_en, mem_rw, mem_addr, mem_wdata, a_ack);
      end
      tick();
      checks++;
      if ({a_ack, a_err, a_rdata, mem_en} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
         failures++;
         $display("FAIL write_ack: got ack=%b err=%b rdata=%h en=%b, required ack=1 err=0 rdata=0 en=0",
                  a_ack, a_err, a_rdata, mem_en);
      end
      a_req = 1'b0;
      tick();
      a_req = 1'b1; a_we = 1'b0; a_addr = 32'h10; a_wdata = 32'h0;
      tick();
      checks++;
      if ({mem_en, mem_rw, mem_addr, a_ack} !== {1'b1, 1'b0, 32'h10, 1'b0}) begin
         failures++;
         $display("FAIL read_issue: got en=%b rw=%b addr=%h ack=%b, required en=1 rw=0 addr=10 ack=0",
                  mem_en, mem_rw, mem_addr, a_ack);
      end
      tick();
      checks++;
      if ({a_ack, a_err, a_rdata, mem_en} !== {1'b1, 1'b0, 32'hDEADBEEF, 1'b0}) begin
         failures++;
         $display("FAIL read_ack: got ack=%b err=%b rdata=%h en=%b, required ack=1 err=0 rdata=deadbeef en=0",
                  a_ack, a_err, a_rdata, mem_en);
      end
      a_req = 1'b0;
      tick();
   endtask

   task automatic test_error();
      b_req = 1'b1; b_we = 1'b0; b_addr = 32'h0001_0000; b_wdata = 32'h0;
      tick();
      checks++;
      if ({b_ack, b_err, b_rdata, mem_en, a_ack} !== {1'b1, 1'b1, 32'd0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL range_error: got b_ack=%b b_err=%b b_rdata=%h en=%b a_ack=%b, required 1 1 0 0 0",
                  b_ack, b_err, b_rdata, mem_en, a_ack);
      end
      b_req = 1'b0;
      tick();
      checks++;
      if ({b_ack, b_err, mem_en} !== 3'b000) begin
         failures++;
         $display("FAIL range_error_after: got b_ack=%b b_err=%b en=%b, required 0 0 0", b_ack, b_err, mem_en);
      end
   endtask

   task automatic test_round_robin();
      logic        exp_b;
      logic [31:0] exp_addr;
      int          prev_ack;
      prev_ack = 0;
      a_req = 1'b1; a_we = 1'b0; a_addr = 32'h1;
      b_req = 1'b1; b_we = 1'b0; b_addr = 32'h2;
      for (int i = 0; i < 4; i++) begin
         exp_b    = (i % 2) == 1;
         exp_addr = exp_b ? 32'h2 : 32'h1;
         tick();
         checks++;
         if ({mem_en, mem_rw, mem_addr, a_ack, b_ack} !== {1'b1, 1'b0, exp_addr, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL rr_issue%0d: got en=%b rw=%b addr=%h acks=%b%b, required en=1 rw=0 addr=%h acks=00",
                     i, mem_en, mem_rw, mem_addr, a_ack, b_ack, exp_addr);
         end
         tick();
         checks++;
         if ({a_ack, b_ack, a_rdata, b_rdata, mem_en} !== {!exp_b, exp_b, 32'd0, 32'd0, 1'b0}) begin
            failures++;
            $display("FAIL rr_ack%0d: got a_ack=%b b_ack=%b rdata=%h/%h en=%b, required a_ack=%b b_ack=%b rdata=0/0 en=0",
                     i, a_ack, b_ack, a_rdata, b_rdata, mem_en, !exp_b, exp_b);
         end
         if (i > 0) begin
            checks++;
            if (cyc - prev_ack != 3) begin
               failures++;
               $display("FAIL rr_spacing%0d: got %0d cycles between acks, required 3", i, cyc - prev_ack);
            end
         end
         prev_ack = cyc;
         tick();
      end
      a_req = 1'b0;
      b_req = 1'b0;
      tick();
      checks++;
      if ({a_ack, b_ack, mem_en, busy} !== 4'b0000) begin
         failures++;
         $display("FAIL rr_release: got acks=%b%b en=%b busy=%b, required 0000", a_ack, b_ack, mem_en, busy);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] exp_addr;
      a_req = 1'b1; a_we = 1'b1; a_addr = 32'h20; a_wdata = 32'h1234_5678;
      tick();
      checks++;
      if ({mem_en, mem_addr} !== {1'b1, 32'h20}) begin
         failures++;
         $display("FAIL midrst_issue: got en=%b addr=%h, required en=1 addr=20", mem_en, mem_addr);
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({a_ack, a_err, b_ack, b_err, busy, clear_done, mem_en, mem_rw, mem_addr, mem_wdata} !== 72'd0) begin
         failures++;
         $display("FAIL midrst_outputs: got ack=%b busy=%b cd=%b en=%b rw=%b addr=%h wd=%h, required all 0",
                  a_ack, busy, clear_done, mem_en, mem_rw, mem_addr, mem_wdata);
      end
      a_req = 1'b0;
      rst   = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         exp_addr = k;
         checks++;
         if ({mem_en, mem_rw, mem_addr, mem_wdata, a_ack, clear_done} !== {1'b1, 1'b1, exp_addr, 32'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL midrst_clear%0d: got en=%b rw=%b addr=%h wd=%h ack=%b cd=%b, required en=1 rw=1 addr=%h wd=0 ack=0 cd=0",
                     k, mem_en, mem_rw, mem_addr, mem_wdata, a_ack, clear_done, exp_addr);
         end
      end
      tick();
      checks++;
      if ({clear_done, busy, a_ack, mem_en} !== 4'b1000) begin
         failures++;
         $display("FAIL midrst_done: got cd=%b busy=%b ack=%b en=%b, required 1 0 0 0", clear_done, busy, a_ack, mem_en);
      end
   endtask

   task automatic test_no_clear();
      tick();
      checks++;
      if ({n_a_ack, n_busy, n_clear_done, n_mem_en, n_mem_addr} !== 36'd0) begin
         failures++;
         $display("FAIL nc_reset: got ack=%b busy=%b cd=%b en=%b addr=%h, required all 0",
                  n_a_ack, n_busy, n_clear_done, n_mem_en, n_mem_addr);
      end
      n_rst = 1'b0;
      tick();
      checks++;
      if ({n_clear_done, n_busy, n_mem_en} !== 3'b100) begin
         failures++;
         $display("FAIL nc_idle: got cd=%b busy=%b en=%b, required cd=1 busy=0 en=0", n_clear_done, n_busy, n_mem_en);
      end
      n_a_req = 1'b1; n_a_we = 1'b0; n_a_addr = 32'h3;
      tick();
      checks++;
      if ({n_mem_en, n_mem_rw, n_mem_addr, n_a_ack} !== {1'b1, 1'b0, 32'h3, 1'b0}) begin
         failures++;
         $display("FAIL nc_issue: got en=%b rw=%b addr=%h ack=%b, required en=1 rw=0 addr=3 ack=0",
                  n_mem_en, n_mem_rw, n_mem_addr, n_a_ack);
      end
      tick();
      checks++;
      if ({n_a_ack, n_a_err, n_a_rdata} !== {1'b1, 1'b0, 32'hA5A5_0003}) begin
         failures++;
         $display("FAIL nc_read: got ack=%b err=%b rdata=%h, required ack=1 err=0 rdata=a5a50003",
                  n_a_ack, n_a_err, n_a_rdata);
      end
      n_a_req = 1'b0;
      tick();
      checks++;
      if ({n_a_ack, n_busy} !== 2'b00) begin
         failures++;
         $display("FAIL nc_release: got ack=%b busy=%b, required 0 0", n_a_ack, n_busy);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem1[i] = 32'hFFFF_FFFF;
         mem2[i] = 32'h0;
      end
      mem2[3]     = 32'hA5A5_0003;
      mem_rdata   = 32'h0;
      n_mem_rdata = 32'h0;
      rst = 1'b1;
      a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
      n_rst = 1'b1;
      n_a_req = 1'b0; n_a_we = 1'b0; n_a_addr = '0; n_a_wdata = '0;
      n_b_req = 1'b0; n_b_we = 1'b0; n_b_addr = '0; n_b_wdata = '0;
      #1;
      test_reset();
      test_clear();
      test_write_read();
      test_error();
      test_round_robin();
      test_reset_mid();
      test_no_clear();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
